// File: rtl/otter_mem_arbiter_if.sv
// Bus bundle for otter_mem_arbiter: the IF and D requester channels and the shared memory port.
// The slave modport is the arbiter's view. The master modport is the view of the requesters and memory.
interface otter_mem_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              IF_REQ;
    logic [ADDR_W-1:0] IF_ADDR;
    logic              IF_GNT;
    logic              IF_RVALID;
    logic [DATA_W-1:0] IF_RDATA;

    logic              D_REQ;
    logic              D_WE;
    logic [ADDR_W-1:0] D_ADDR;
    logic [DATA_W-1:0] D_WDATA;
    logic [1:0]        D_SIZE;
    logic              D_SIGN;
    logic              D_GNT;
    logic              D_RVALID;
    logic [DATA_W-1:0] D_RDATA;

    logic              M_REQ;
    logic              M_WE;
    logic [ADDR_W-1:0] M_ADDR;
    logic [DATA_W-1:0] M_WDATA;
    logic [1:0]        M_SIZE;
    logic              M_SIGN;
    logic [DATA_W-1:0] M_RDATA;

    modport slave (
        input  IF_REQ, IF_ADDR, D_REQ, D_WE, D_ADDR, D_WDATA, D_SIZE, D_SIGN, M_RDATA,
        output IF_GNT, IF_RVALID, IF_RDATA, D_GNT, D_RVALID, D_RDATA,
        output M_REQ, M_WE, M_ADDR, M_WDATA, M_SIZE, M_SIGN
    );

    modport master (
        output IF_REQ, IF_ADDR, D_REQ, D_WE, D_ADDR, D_WDATA, D_SIZE, D_SIGN, M_RDATA,
        input  IF_GNT, IF_RVALID, IF_RDATA, D_GNT, D_RVALID, D_RDATA,
        input  M_REQ, M_WE, M_ADDR, M_WDATA, M_SIZE, M_SIGN
    );
endinterface

// File: rtl/otter_mem_arbiter.sv
// Single-port memory arbiter that shares one port between OTTER instruction fetch (IF) and data (D).
// Defining OTTER_ARB_STARVE_GUARD_EN forces an IF grant after STARVE_MAX consecutive IF denials.
module otter_mem_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input logic                CLK,
    input logic                RST,
    otter_mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StIfPend, StDPend} state_e;

    state_e state_q, state_d;
    logic   force_if;
    logic   if_gnt;
    logic   d_gnt;

`ifdef OTTER_ARB_STARVE_GUARD_EN
    localparam int unsigned     CntW   = $clog2(STARVE_MAX + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(STARVE_MAX);

    logic [CntW-1:0] starve_q, starve_d;

    assign force_if = bus.IF_REQ && (starve_q == CntMax);

    always_comb begin
        starve_d = starve_q;
        if (!bus.IF_REQ || if_gnt) begin
            starve_d = '0;
        end else if (starve_q != CntMax) begin
            starve_d = starve_q + CntW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) starve_q <= '0;
        else     starve_q <= starve_d;
    end
`else
    logic unused_starve_max;
    assign unused_starve_max = (STARVE_MAX == 0);
    assign force_if          = 1'b0;
`endif

    // Grants are masked during reset so every output reads as its reset value.
    always_comb begin
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        if (!RST) begin
            if (bus.IF_REQ && (!bus.D_REQ || force_if)) begin
                if_gnt = 1'b1;
            end else if (bus.D_REQ) begin
                d_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        bus.IF_GNT  = if_gnt;
        bus.D_GNT   = d_gnt;
        bus.M_REQ   = 1'b0;
        bus.M_WE    = 1'b0;
        bus.M_ADDR  = {ADDR_W{1'b0}};
        bus.M_WDATA = {DATA_W{1'b0}};
        bus.M_SIZE  = 2'b00;
        bus.M_SIGN  = 1'b0;
        if (if_gnt) begin
            bus.M_REQ  = 1'b1;
            bus.M_ADDR = bus.IF_ADDR;
            bus.M_SIZE = 2'b10;
        end else if (d_gnt) begin
            bus.M_REQ   = 1'b1;
            bus.M_WE    = bus.D_WE;
            bus.M_ADDR  = bus.D_ADDR;
            bus.M_WDATA = bus.D_WDATA;
            bus.M_SIZE  = bus.D_SIZE;
            bus.M_SIGN  = bus.D_SIGN;
        end
    end

    // Owner of next cycle's read data. Writes return nothing.
    always_comb begin
        state_d = StIdle;
        if (if_gnt) begin
            state_d = StIfPend;
        end else if (d_gnt && !bus.D_WE) begin
            state_d = StDPend;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) state_q <= StIdle;
        else     state_q <= state_d;
    end

    always_comb begin
        bus.IF_RVALID = 1'b0;
        bus.IF_RDATA  = {DATA_W{1'b0}};
        bus.D_RVALID  = 1'b0;
        bus.D_RDATA   = {DATA_W{1'b0}};
        if (!RST) begin
            unique case (state_q)
                StIfPend: begin
                    bus.IF_RVALID = 1'b1;
                    bus.IF_RDATA  = bus.M_RDATA;
                end
                StDPend: begin
                    bus.D_RVALID = 1'b1;
                    bus.D_RDATA  = bus.M_RDATA;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_otter_mem_arbiter.sv
// Directed testbench for otter_mem_arbiter: a per-cycle reference model plus literal checks of key cases.
// It follows OTTER_ARB_STARVE_GUARD_EN in the same way as the design.
module tb_otter_mem_arbiter;
    localparam int SMAX = 4;

    logic CLK = 1'b0;
    logic RST;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   run_cmp = 1'b0;

    // Model state: 0 none, 1 IF owns the next read data, 2 D owns it.
    int   m_owner = 0;
    int   m_starve = 0;

    otter_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    otter_mem_arbiter #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .STARVE_MAX(SMAX)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Returns {if_gnt, d_gnt} from the current requests and the model's denial count.
    function automatic logic [1:0] model_gnt();
        bit f;
        bit ig;
        f = 1'b0;
`ifdef OTTER_ARB_STARVE_GUARD_EN
        f = bus.IF_REQ && (m_starve >= SMAX);
`endif
        if (RST) return 2'b00;
        ig = bus.IF_REQ && (!bus.D_REQ || f);
        return {ig, bus.D_REQ && !ig};
    endfunction

    always @(posedge CLK) begin
        logic [1:0] g;
        g = model_gnt();
        if (RST)                   m_owner <= 0;
        else if (g[1])             m_owner <= 1;
        else if (g[0] && !bus.D_WE) m_owner <= 2;
        else                       m_owner <= 0;
        if (RST || !bus.IF_REQ || g[1]) m_starve <= 0;
        else if (m_starve < SMAX)       m_starve <= m_starve + 1;
    end

    always @(negedge CLK) begin
        if (run_cmp) begin
            logic [1:0] g;
            bit ifv;
            bit dv;
            g   = model_gnt();
            ifv = !RST && (m_owner == 1);
            dv  = !RST && (m_owner == 2);
            chk("m_if_gnt", bus.IF_GNT, g[1]);
            chk("m_d_gnt", bus.D_GNT, g[0]);
            chk("m_req", bus.M_REQ, g[1] | g[0]);
            chk("m_we", bus.M_WE, g[0] & bus.D_WE);
            chk("m_addr", bus.M_ADDR, g[1] ? bus.IF_ADDR : (g[0] ? bus.D_ADDR : 32'h0));
            chk("m_wdata", bus.M_WDATA, g[0] ? bus.D_WDATA : 32'h0);
            chk("m_size", bus.M_SIZE, g[1] ? 2'b10 : (g[0] ? bus.D_SIZE : 2'b00));
            chk("m_sign", bus.M_SIGN, g[0] & bus.D_SIGN);
            chk("m_if_rvalid", bus.IF_RVALID, ifv);
            chk("m_if_rdata", bus.IF_RDATA, ifv ? bus.M_RDATA : 32'h0);
            chk("m_d_rvalid", bus.D_RVALID, dv);
            chk("m_d_rdata", bus.D_RDATA, dv ? bus.M_RDATA : 32'h0);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_d(input bit req, input bit we, input logic [31:0] a, input logic [31:0] wd);
        bus.D_REQ   = req;
        bus.D_WE    = we;
        bus.D_ADDR  = a;
        bus.D_WDATA = wd;
    endtask

    initial begin
        bit exp_if;
        RST         = 1'b1;
        bus.IF_REQ  = 1'b1;
        bus.IF_ADDR = 32'h0000_0040;
        bus.D_SIZE  = 2'b10;
        bus.D_SIGN  = 1'b1;
        bus.M_RDATA = 32'h0BAD_F00D;
        set_d(1'b1, 1'b0, 32'h0000_0080, 32'h0);
        run_cmp = 1'b1;

        // Two reset cycles with both requests high.
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            chk("rst_if_gnt", bus.IF_GNT, 1'b0);
            chk("rst_d_gnt", bus.D_GNT, 1'b0);
            chk("rst_m_req", bus.M_REQ, 1'b0);
            chk("rst_m_addr", bus.M_ADDR, 32'h0);
            tick();
        end

        // IF-only read.
        RST = 1'b0;
        bus.IF_ADDR = 32'h0000_0100;
        set_d(1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge CLK);
        chk("if_gnt", bus.IF_GNT, 1'b1);
        chk("if_m_addr", bus.M_ADDR, 32'h0000_0100);
        tick();
        bus.IF_REQ  = 1'b0;
        bus.M_RDATA = 32'hDEAD_BEEF;
        @(negedge CLK);
        chk("if_rvalid", bus.IF_RVALID, 1'b1);
        chk("if_rdata", bus.IF_RDATA, 32'hDEAD_BEEF);
        chk("if_d_rvalid", bus.D_RVALID, 1'b0);
        chk("if_d_rdata", bus.D_RDATA, 32'h0);
        tick();

        // D write.
        bus.D_SIGN = 1'b0;
        set_d(1'b1, 1'b1, 32'h1100_0000, 32'h0000_0055);
        @(negedge CLK);
        chk("wr_m_we", bus.M_WE, 1'b1);
        chk("wr_m_addr", bus.M_ADDR, 32'h1100_0000);
        chk("wr_m_wdata", bus.M_WDATA, 32'h0000_0055);
        tick();
        set_d(1'b0, 1'b0, 32'h0, 32'h0);
        bus.M_RDATA = 32'h0000_1234;
        @(negedge CLK);
        chk("wr_no_d_rvalid", bus.D_RVALID, 1'b0);
        chk("wr_no_if_rvalid", bus.IF_RVALID, 1'b0);
        tick();

        // Back-to-back IF read then D read.
        bus.IF_REQ  = 1'b1;
        bus.IF_ADDR = 32'h0000_0200;
        @(negedge CLK);
        chk("b2b_if_gnt", bus.IF_GNT, 1'b1);
        tick();
        bus.IF_REQ  = 1'b0;
        bus.D_SIGN  = 1'b1;
        bus.D_SIZE  = 2'b01;
        set_d(1'b1, 1'b0, 32'h0000_0300, 32'h0);
        bus.M_RDATA = 32'hAAAA_0001;
        @(negedge CLK);
        chk("b2b_if_rdata", bus.IF_RDATA, 32'hAAAA_0001);
        chk("b2b_d_gnt", bus.D_GNT, 1'b1);
        chk("b2b_d_rvalid0", bus.D_RVALID, 1'b0);
        tick();
        set_d(1'b0, 1'b0, 32'h0, 32'h0);
        bus.M_RDATA = 32'hBBBB_0002;
        @(negedge CLK);
        chk("b2b_d_rdata", bus.D_RDATA, 32'hBBBB_0002);
        chk("b2b_if_rvalid1", bus.IF_RVALID, 1'b0);
        tick();

        // Contention: both requests held high.
        bus.IF_REQ  = 1'b1;
        bus.IF_ADDR = 32'h0000_0500;
        set_d(1'b1, 1'b0, 32'h0000_0600, 32'h0);
        for (int i = 0; i < 10; i++) begin
            bus.M_RDATA = 32'hC000_0000 + i;
            @(negedge CLK);
`ifdef OTTER_ARB_STARVE_GUARD_EN
            exp_if = (i % 5 == 4);
`else
            exp_if = 1'b0;
`endif
            chk("cont_if_gnt", bus.IF_GNT, exp_if);
            chk("cont_d_gnt", bus.D_GNT, !exp_if);
            tick();
        end

        // Reset right after a D read grant.
        bus.IF_REQ = 1'b0;
        set_d(1'b1, 1'b0, 32'h0000_0400, 32'h0);
        @(negedge CLK);
        chk("rmid_d_gnt", bus.D_GNT, 1'b1);
        tick();
        RST = 1'b1;
        set_d(1'b0, 1'b0, 32'h0, 32'h0);
        bus.M_RDATA = 32'h7777_7777;
        @(negedge CLK);
        chk("rmid_d_rvalid", bus.D_RVALID, 1'b0);
        chk("rmid_d_rdata", bus.D_RDATA, 32'h0);
        tick();
        RST = 1'b0;
        bus.IF_REQ = 1'b1;
        set_d(1'b1, 1'b0, 32'h0000_0404, 32'h0);
        @(negedge CLK);
        chk("rmid_first_d", bus.D_GNT, 1'b1);
        chk("rmid_first_if", bus.IF_GNT, 1'b0);
        tick();

        bus.IF_REQ = 1'b0;
        set_d(1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        tick();
        @(negedge CLK);
        run_cmp = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
